// File: rtl/fetch_unit_pkg.sv
//==============================================================================
// Module      : fetch_unit_pkg
// Description : Shared CPU fetch definitions: widths, instruction memory size,
//               reset PC and the packed {pc, instr} prefetch entry.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int ADDR_W    = 16;
    localparam int INSTR_W   = 16;
    localparam int MEM_WORDS = 64;
    localparam int ENTRY_W   = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // One prefetch queue slot: the byte PC travels with its instruction word.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [ADDR_W-1:0]  pc,
                                                input logic [INSTR_W-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
//==============================================================================
// Module      : fetch_unit_queue
// Description : Prefetch FIFO between the PC logic and decode. Push is taken
//               while full when a pop happens in the same cycle; flush wins
//               over push and pop. Head data comes straight from the storage
//               registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle;
    // the freed slot is the one the write pointer already points at.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch controller. Owns the PC, reads the
//               combinational word-aligned instruction memory, buffers words
//               in a small prefetch queue and hands them to decode over
//               valid/ready. Handles redirects, halt and sticky fetch faults.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [ADDR_W:0] c_PC_LIMIT = (ADDR_W + 1)'(2 * MEM_WORDS);

    logic [ADDR_W-1:0] r_pc;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_pc;

    logic              w_pc_ok;
    logic              w_may_fetch;
    logic              w_pop;
    logic              w_room;
    logic              w_push;
    logic              w_fault_set;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;
    logic [ENTRY_W-1:0] w_rdata;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_unused_count;

    // A fetch is legal only on an even byte address inside the memory.
    assign w_pc_ok     = ~r_pc[0] & ({1'b0, r_pc} < c_PC_LIMIT);
    // Redirect, halt and a pending fault all stop the PC from issuing.
    assign w_may_fetch = ~halt & ~r_fault & ~redirect_valid;
    assign w_pop       = out_valid & out_ready;
    assign w_room      = ~w_full | w_pop;
    assign w_push      = w_may_fetch & w_room & w_pc_ok;
    assign w_fault_set = w_may_fetch & ~w_pc_ok;

    assign w_wr_entry  = make_entry(r_pc, imem_instr);
    assign w_head      = fetch_entry_t'(w_rdata);

    assign imem_addr   = r_pc;
    assign out_valid   = ~w_empty;
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;

    // Occupancy is only needed inside the queue; full/empty carry the control.
    assign w_unused_count = ^w_count;

    // Program counter: a redirect always lands, otherwise step on each push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(2);
        end
    end

    // Sticky fault: captured on the first illegal fetch, cleared by redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (w_fault_set) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
        end
    end

    fetch_unit_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a behavioural instruction
//               memory and an in-order scoreboard of expected {pc, instr}.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready = 1'b0;
    logic        fault;
    logic [15:0] fault_pc;

    logic [15:0] mem [64];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          used;

    always #5 clk = ~clk;

    // Combinational word-addressed memory; out-of-range reads return a marker.
    always_comb begin
        imem_instr = 16'hDEAD;
        if (imem_addr < 16'd128) imem_instr = mem[imem_addr[6:1]];
    end

    fetch_unit #(.QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem[pc[6:1]];
        sb.push_back(e);
    endtask

    // Settle after the inputs change, then score any beat decode takes at
    // the coming rising edge (redirect and reset discard it).
    task automatic sample();
        exp_t e;
        #1;
        if (!rst && !redirect_valid && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("beat_unexpected", {16'h0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("beat_pc", {16'h0, out_pc}, {16'h0, e.pc});
                check("beat_instr", {16'h0, out_instr}, {16'h0, e.instr});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    task automatic drain(input int max_cycles, output int cycles);
        cycles = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            cyc();
            cycles++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0111) ^ 16'h5A3C;

        // Reset state
        tick(); tick(); tick();
        sample();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_pc", fault_pc, 0);
        check("rst_imem_addr", imem_addr, 0);

        // Release with ready high: one cycle latency, then back-to-back beats
        rst = 1'b0; out_ready = 1'b1;
        expect_pc(16'h0000); expect_pc(16'h0002); expect_pc(16'h0004); expect_pc(16'h0006);
        sample();
        check("t1_latency_empty", out_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t1_back_to_back", out_valid, 1);
            tick();
        end
        check("t1_sb_empty", sb.size(), 0);

        // Backpressure: queue fills at two entries, PC parks at 4
        rst = 1'b1; out_ready = 1'b0;
        sample();
        check("t2_async_rst_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        sample();
        check("t2_full_addr", imem_addr, 16'h0004);
        check("t2_full_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        expect_pc(16'h0000); expect_pc(16'h0002); expect_pc(16'h0004);
        drain(10, used);
        check("t2_no_gaps", used, 3);

        // Redirect while full and popping: the popped head is discarded
        redirect_valid = 1'b1; redirect_pc = 16'h0014;
        sample();
        check("t3_full_before", out_valid, 1);
        tick();
        redirect_valid = 1'b0;
        sample();
        check("t3_flushed", out_valid, 0);
        check("t3_target_addr", imem_addr, 16'h0014);
        tick();
        expect_pc(16'h0014);
        drain(4, used);
        check("t3_target_latency", used, 1);

        // Misaligned redirect faults the following cycle; redirect clears it
        redirect_valid = 1'b1; redirect_pc = 16'h0003;
        cyc();
        redirect_valid = 1'b0;
        sample();
        check("t4_not_yet", fault, 0);
        tick();
        sample();
        check("t4_fault", fault, 1);
        check("t4_fault_pc", fault_pc, 16'h0003);
        check("t4_no_entries", out_valid, 0);
        tick();
        sample();
        check("t4_pc_holds", imem_addr, 16'h0003);
        check("t4_still_empty", out_valid, 0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        sample();
        check("t4_sticky", fault, 1);
        tick();
        redirect_valid = 1'b0;
        sample();
        check("t4_cleared", fault, 0);
        check("t4_cleared_pc", fault_pc, 0);
        tick();
        expect_pc(16'h0000);
        drain(4, used);

        // Run off the end of memory: 0x7E delivered, 0x80 faults
        redirect_valid = 1'b1; redirect_pc = 16'h007A;
        cyc();
        redirect_valid = 1'b0;
        expect_pc(16'h007A); expect_pc(16'h007C); expect_pc(16'h007E);
        drain(8, used);
        sample();
        check("t5_fault", fault, 1);
        check("t5_fault_pc", fault_pc, 16'h0080);
        check("t5_empty", out_valid, 0);
        tick();

        // Halt: queue drains, PC holds, resume at the held PC
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        cyc();
        redirect_valid = 1'b0;
        expect_pc(16'h0020); expect_pc(16'h0022);
        drain(6, used);
        halt = 1'b1;
        expect_pc(16'h0024);
        sample();
        check("t6_halt_addr", imem_addr, 16'h0026);
        tick();
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t6_halt_drained", out_valid, 0);
            check("t6_halt_hold", imem_addr, 16'h0026);
            tick();
        end
        halt = 1'b0;
        expect_pc(16'h0026); expect_pc(16'h0028);
        drain(6, used);
        check("t6_resume_cycles", used, 3);

        // Reset mid-stream with two queued entries
        out_ready = 1'b0;
        cyc();
        sample();
        check("t7_full_addr", imem_addr, 16'h002E);
        check("t7_full_valid", out_valid, 1);
        rst = 1'b1;
        sample();
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_fault", fault, 0);
        check("t7_rst_addr", imem_addr, 16'h0000);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        expect_pc(16'h0000); expect_pc(16'h0002);
        drain(6, used);
        check("t7_restart_cycles", used, 3);
        out_ready = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
